programmable_sequence_detector: RTL and testbench

- Serial bit-stream pattern detector with a run-time programmable target pattern of LEN bits.
- The target is captured once, from `init`, on the first clock edge after reset release, and then frozen until the next reset.
- `seen` flags every position where the last LEN received bits equal the target. Overlapping matches count.
- Sits on a 1-bit serial data path as a match/trigger source.

---
 rtl/programmable_sequence_detector.sv | 65 ++++++
 tb/tb_programmable_sequence_detector.sv | 126 ++++++++++++
 2 files changed

// File: rtl/programmable_sequence_detector.sv
// Serial bit-stream detector: flags every position where the last LEN bits
// equal a target pattern captured once on the first edge after reset.
module programmable_sequence_detector #(
  parameter int unsigned LEN = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [LEN-1:0] init,
  input  logic           din,
  output logic           seen
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN-1:0]     target;
  logic [LEN-1:0]     shift;
  logic [CNT_W-1:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_LOAD;
    endcase
  end

  // The first post-reset edge both captures the target and shifts in bit 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift  <= '0;
      count  <= '0;
      target <= init;
    end else begin
      shift <= {shift[LEN-2:0], din};
      if (count != CNT_W'(LEN)) begin
        count <= count + CNT_W'(1);
      end
      if (state == ST_LOAD) begin
        target <= init;
      end
    end
  end

  // Count gate keeps a zero-filled register from matching an all-zero target early.
  always_comb begin
    seen = (count == CNT_W'(LEN)) && (shift == target);
  end

endmodule

// File: tb/tb_programmable_sequence_detector.sv
// Directed self-checking bench for programmable_sequence_detector (LEN=5).
module tb_programmable_sequence_detector;

  localparam int unsigned LEN = 5;

  logic           clk;
  logic           reset;
  logic [LEN-1:0] init;
  logic           din;
  logic           seen;

  int unsigned checks = 0;
  int unsigned errors = 0;

  programmable_sequence_detector #(.LEN(LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .din   (din),
    .seen  (seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One reset edge; din is held high so a wrongly sampled bit would show up.
  task automatic do_reset(input string tag, input logic [LEN-1:0] ini);
    reset = 1'b1;
    init  = ini;
    din   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check(tag, seen, 1'b0);
  endtask

  task automatic feed(input string tag, input logic [LEN-1:0] ini,
                      input logic b, input logic exp);
    init = ini;
    din  = b;
    @(posedge clk);
    #1;
    check(tag, seen, exp);
  endtask

  initial begin
    reset = 1'b1;
    init  = '0;
    din   = 1'b0;
    @(posedge clk);
    #1;

    // Overlapping match: bits 1,1,0,1,1,0,1,1 against 11011.
    do_reset("ovl_rst", 5'b11011);
    feed("ovl_b1", 5'b11011, 1'b1, 1'b0);
    feed("ovl_b2", 5'b11011, 1'b1, 1'b0);
    feed("ovl_b3", 5'b11011, 1'b0, 1'b0);
    feed("ovl_b4", 5'b11011, 1'b1, 1'b0);
    feed("ovl_b5", 5'b11011, 1'b1, 1'b1);
    feed("ovl_b6", 5'b11011, 1'b0, 1'b0);
    feed("ovl_b7", 5'b11011, 1'b1, 1'b0);
    feed("ovl_b8", 5'b11011, 1'b1, 1'b1);

    // History cleared by reset: target 00011, bits 1,1,0,0,0,1,1.
    do_reset("hist_rst", 5'b00011);
    feed("hist_b1", 5'b00011, 1'b1, 1'b0);
    feed("hist_b2", 5'b00011, 1'b1, 1'b0);
    feed("hist_b3", 5'b00011, 1'b0, 1'b0);
    feed("hist_b4", 5'b00011, 1'b0, 1'b0);
    feed("hist_b5", 5'b00011, 1'b0, 1'b0);
    feed("hist_b6", 5'b00011, 1'b1, 1'b0);
    feed("hist_b7", 5'b00011, 1'b1, 1'b1);

    // Target frozen after the first edge; later init values are ignored.
    do_reset("frz_rst", 5'b00000);
    feed("frz_b1", 5'b10101, 1'b1, 1'b0);
    feed("frz_b2", 5'b11110, 1'b0, 1'b0);
    feed("frz_b3", 5'b10110, 1'b1, 1'b0);
    feed("frz_b4", 5'b11011, 1'b0, 1'b0);
    feed("frz_b5", 5'b10001, 1'b1, 1'b1);
    feed("frz_b6", 5'b01010, 1'b0, 1'b0);

    // All-zero target needs LEN bits before seen may rise.
    do_reset("zero_rst", 5'b00000);
    feed("zero_b1", 5'b00000, 1'b0, 1'b0);
    feed("zero_b2", 5'b00000, 1'b0, 1'b0);
    feed("zero_b3", 5'b00000, 1'b0, 1'b0);
    feed("zero_b4", 5'b00000, 1'b0, 1'b0);
    feed("zero_b5", 5'b00000, 1'b0, 1'b1);
    feed("zero_b6", 5'b00000, 1'b0, 1'b1);
    feed("zero_b7", 5'b00000, 1'b0, 1'b1);
    feed("zero_b8", 5'b00000, 1'b1, 1'b0);

    // Reset mid-match: partial 1,1,0,1 must not carry across reset.
    do_reset("mid_rst0", 5'b11011);
    feed("mid_p1", 5'b11011, 1'b1, 1'b0);
    feed("mid_p2", 5'b11011, 1'b1, 1'b0);
    feed("mid_p3", 5'b11011, 1'b0, 1'b0);
    feed("mid_p4", 5'b11011, 1'b1, 1'b0);
    do_reset("mid_rst1", 5'b11011);
    feed("mid_b1", 5'b11011, 1'b1, 1'b0);
    feed("mid_b2", 5'b11011, 1'b1, 1'b0);
    feed("mid_b3", 5'b11011, 1'b0, 1'b0);
    feed("mid_b4", 5'b11011, 1'b1, 1'b0);
    feed("mid_b5", 5'b11011, 1'b1, 1'b1);

    // Continuous all-ones.
    do_reset("ones_rst", 5'b11111);
    for (int i = 1; i <= 8; i++) begin
      feed($sformatf("ones_b%0d", i), 5'b11111, 1'b1, (i >= 5) ? 1'b1 : 1'b0);
    end
    feed("ones_drop", 5'b11111, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
